// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the SIMD pipeline hazard controller: forwarding selects,
// stall FSM states and the in-flight scoreboard entry.
package pipe_ctrl_pkg;

    // Scoreboard destination width; register addresses up to this width are supported.
    localparam int SB_DEST_W = 8;
    localparam int CNT_W     = 3;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [SB_DEST_W-1:0] dest;
        logic                 wb;
        logic                 ld;
    } sb_entry_t;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding select: the younger producer (MEM) beats WB, and a
// load still in MEM has no data on the EX/MEM path yet.
module fwd_select
    import pipe_ctrl_pkg::*;
(
    input  logic [SB_DEST_W-1:0] src,
    input  logic                 use_src,
    input  sb_entry_t            mem,
    input  sb_entry_t            wb,
    output fwd_sel_t             sel
);

    logic unused_wb_ld;
    assign unused_wb_ld = wb.ld;

    always_comb begin
        sel = FWD_RF;
        if (use_src) begin
            if (mem.valid && mem.wb && !mem.ld && mem.dest == src)
                sel = FWD_EXMEM;
            else if (wb.valid && wb.wb && wb.dest == src)
                sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ID->EXE sequencing for the 16-bit SIMD pipeline: load-use stall FSM,
// EXE/MEM/WB destination scoreboard, operand forwarding and EXE flush.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW  = 4,
    parameter int MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src_a,
    input  logic [REG_AW-1:0] id_src_b,
    input  logic              id_use_a,
    input  logic              id_use_b,
    input  logic [REG_AW-1:0] id_destiny,
    input  logic              id_writeBack,
    input  logic              id_mem_rd,
    input  logic              flush_req,
    output logic              stall_fetch,
    output logic              stall_decode,
    output logic              bubble_id_exe,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic              busy
);

    sb_entry_t            exe_q, mem_q, wb_q, exe_d;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SB_DEST_W-1:0] src_a, src_b;
    logic                 hazard, stall, bubble;
    fwd_sel_t             sel_a, sel_b;

    assign src_a = SB_DEST_W'(id_src_a);
    assign src_b = SB_DEST_W'(id_src_b);

    always_comb begin
        hazard = id_valid && exe_q.valid && exe_q.wb && exe_q.ld &&
                 ((id_use_a && exe_q.dest == src_a) || (id_use_b && exe_q.dest == src_b));
        stall  = !flush_req && (state_q == STALL || hazard);
        bubble = flush_req || stall;

        // The hazard cycle itself is the first stall cycle, so STALL covers MEM_LAT-1 more.
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_req) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hazard && MEM_LAT > 1) begin
                        state_d = STALL;
                        cnt_d   = CNT_W'(MEM_LAT - 1);
                    end
                end
                STALL: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            endcase
        end

        exe_d = '0;
        if (!bubble) begin
            exe_d.valid = id_valid;
            exe_d.dest  = SB_DEST_W'(id_destiny);
            exe_d.wb    = id_valid && id_writeBack;
            exe_d.ld    = id_valid && id_mem_rd;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exe_q   <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            exe_q   <= exe_d;
            mem_q   <= exe_q;
            wb_q    <= mem_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    fwd_select u_fwd_a (
        .src     (src_a),
        .use_src (id_valid && id_use_a),
        .mem     (mem_q),
        .wb      (wb_q),
        .sel     (sel_a)
    );

    fwd_select u_fwd_b (
        .src     (src_b),
        .use_src (id_valid && id_use_b),
        .mem     (mem_q),
        .wb      (wb_q),
        .sel     (sel_b)
    );

    assign stall_fetch   = stall;
    assign stall_decode  = stall;
    assign bubble_id_exe = bubble;
    assign fwd_sel_a     = sel_a;
    assign fwd_sel_b     = sel_b;
    assign busy          = (state_q == STALL);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MEM_LAT=2 and hand-computed expectations.
module tb_pipeline_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       id_valid, id_use_a, id_use_b, id_writeBack, id_mem_rd, flush_req;
    logic [3:0] id_src_a, id_src_b, id_destiny;
    logic       stall_fetch, stall_decode, bubble_id_exe, busy;
    logic [1:0] fwd_sel_a, fwd_sel_b;

    int errors = 0;
    int checks = 0;

    pipeline_hazard_ctrl #(.REG_AW(4), .MEM_LAT(2)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .id_valid     (id_valid),
        .id_src_a     (id_src_a),
        .id_src_b     (id_src_b),
        .id_use_a     (id_use_a),
        .id_use_b     (id_use_b),
        .id_destiny   (id_destiny),
        .id_writeBack (id_writeBack),
        .id_mem_rd    (id_mem_rd),
        .flush_req    (flush_req),
        .stall_fetch  (stall_fetch),
        .stall_decode (stall_decode),
        .bubble_id_exe(bubble_id_exe),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drv(input logic v, input logic [3:0] sa, input logic ua,
                       input logic [3:0] sb, input logic ub, input logic [3:0] d,
                       input logic w, input logic ld, input logic fl);
        id_valid = v; id_src_a = sa; id_use_a = ua; id_src_b = sb; id_use_b = ub;
        id_destiny = d; id_writeBack = w; id_mem_rd = ld; flush_req = fl;
        #1;
    endtask

    task automatic nop();            drv(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); endtask
    task automatic ld_r(input logic [3:0] d); drv(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, d, 1'b1, 1'b1, 1'b0); endtask
    task automatic alu(input logic [3:0] d, input logic [3:0] a, input logic [3:0] b);
        drv(1'b1, a, 1'b1, b, 1'b1, d, 1'b1, 1'b0, 1'b0);
    endtask
    task automatic drain();
        nop(); tick(); tick(); tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stf"}, int'(stall_fetch), 0);
        chk({tag, "_std"}, int'(stall_decode), 0);
        chk({tag, "_bub"}, int'(bubble_id_exe), 0);
        chk({tag, "_fa"},  int'(fwd_sel_a), 0);
        chk({tag, "_fb"},  int'(fwd_sel_b), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        nop();
        #1;
        chk_all_zero("rst");
        #2 reset_n = 1'b1;
        #1;
        chk_all_zero("rst_rel");

        // Load r3, then add r7 <- r3 + r9: two stall cycles, then forward from WB.
        tick();
        ld_r(4'd3);
        chk("lu_ld_nostall", int'(stall_fetch), 0);
        tick();
        alu(4'd7, 4'd3, 4'd9);
        chk("lu_c0_stf", int'(stall_fetch), 1);
        chk("lu_c0_std", int'(stall_decode), 1);
        chk("lu_c0_bub", int'(bubble_id_exe), 1);
        chk("lu_c0_busy", int'(busy), 0);
        tick();
        chk("lu_c1_stf", int'(stall_fetch), 1);
        chk("lu_c1_bub", int'(bubble_id_exe), 1);
        chk("lu_c1_busy", int'(busy), 1);
        tick();
        chk("lu_c2_stf", int'(stall_fetch), 0);
        chk("lu_c2_bub", int'(bubble_id_exe), 0);
        chk("lu_c2_busy", int'(busy), 0);
        chk("lu_c2_fa", int'(fwd_sel_a), 2);
        chk("lu_c2_fb", int'(fwd_sel_b), 0);
        tick();
        drain();

        // ALU chain on r5: producer in EXE gives no path and no stall; in MEM -> 1; in WB -> 2.
        alu(4'd5, 4'd1, 4'd2);
        tick();
        alu(4'd6, 4'd5, 4'd5);
        chk("alu_exe_stf", int'(stall_fetch), 0);
        chk("alu_exe_fa", int'(fwd_sel_a), 0);
        tick();
        alu(4'd6, 4'd5, 4'd5);
        chk("alu_mem_fa", int'(fwd_sel_a), 1);
        chk("alu_mem_fb", int'(fwd_sel_b), 1);
        chk("alu_mem_stf", int'(stall_fetch), 0);
        tick();
        alu(4'd9, 4'd5, 4'd12);
        chk("alu_wb_fa", int'(fwd_sel_a), 2);
        chk("alu_wb_fb", int'(fwd_sel_b), 0);
        tick();
        drain();

        // Two writers of r4 in MEM and WB: MEM wins.
        alu(4'd4, 4'd1, 4'd2); tick();
        alu(4'd4, 4'd2, 4'd3); tick();
        alu(4'd8, 4'd1, 4'd1); tick();
        alu(4'd10, 4'd4, 4'd4);
        chk("dbl_fa", int'(fwd_sel_a), 1);
        chk("dbl_fb", int'(fwd_sel_b), 1);
        tick();
        drain();

        // Same, but the MEM writer is a load: falls through to the WB writer.
        alu(4'd4, 4'd1, 4'd2); tick();
        ld_r(4'd4); tick();
        alu(4'd8, 4'd1, 4'd1); tick();
        drv(1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 4'd10, 1'b1, 1'b0, 1'b0);
        chk("ldmem_fa", int'(fwd_sel_a), 2);
        chk("ldmem_fb", int'(fwd_sel_b), 0);
        tick();
        drain();

        // r0 forwards like any other register.
        alu(4'd0, 4'd1, 4'd2); tick();
        nop(); tick();
        alu(4'd11, 4'd0, 4'd3);
        chk("r0_fa", int'(fwd_sel_a), 1);
        chk("r0_fb", int'(fwd_sel_b), 0);
        tick();
        drain();

        // id_valid=0 with a would-be dependency on the load in EXE.
        ld_r(4'd3); tick();
        drv(1'b0, 4'd3, 1'b1, 4'd3, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
        chk("inv_stf", int'(stall_fetch), 0);
        chk("inv_bub", int'(bubble_id_exe), 0);
        chk("inv_fa", int'(fwd_sel_a), 0);
        tick();
        drain();

        // Unused operand B matching the load destination.
        ld_r(4'd3); tick();
        drv(1'b1, 4'd1, 1'b1, 4'd3, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0);
        chk("unused_stf", int'(stall_fetch), 0);
        chk("unused_fb", int'(fwd_sel_b), 0);
        tick();
        drain();

        // Flush in the hazard cycle.
        ld_r(4'd3); tick();
        drv(1'b1, 4'd3, 1'b1, 4'd9, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1);
        chk("fl_bub", int'(bubble_id_exe), 1);
        chk("fl_stf", int'(stall_fetch), 0);
        chk("fl_std", int'(stall_decode), 0);
        chk("fl_busy", int'(busy), 0);
        tick();
        alu(4'd7, 4'd3, 4'd9);
        chk("fl_next_busy", int'(busy), 0);
        chk("fl_next_stf", int'(stall_fetch), 0);
        chk("fl_next_fa", int'(fwd_sel_a), 0);
        tick();
        drain();

        // Flush on the last STALL cycle.
        ld_r(4'd3); tick();
        alu(4'd7, 4'd3, 4'd9);
        chk("fll_c0_stf", int'(stall_fetch), 1);
        tick();
        drv(1'b1, 4'd3, 1'b1, 4'd9, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1);
        chk("fll_c1_stf", int'(stall_fetch), 0);
        chk("fll_c1_bub", int'(bubble_id_exe), 1);
        tick();
        alu(4'd7, 4'd3, 4'd9);
        chk("fll_c2_busy", int'(busy), 0);
        chk("fll_c2_stf", int'(stall_fetch), 0);
        chk("fll_c2_fa", int'(fwd_sel_a), 2);
        tick();
        drain();

        // Reset dropped in the first STALL cycle.
        ld_r(4'd3); tick();
        alu(4'd7, 4'd3, 4'd9); tick();
        chk("rms_busy", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("rms");
        reset_n = 1'b1;
        #1;
        chk("rms_rel_stf", int'(stall_fetch), 0);
        chk("rms_rel_bub", int'(bubble_id_exe), 0);
        tick();
        chk("rms_rel_busy", int'(busy), 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
